// File: rtl/riscv_scoreboard_nw.sv
// riscv_scoreboard_nw
// N-wide scoreboard for an in-order-issue, out-of-order-completion core.
// Tracks each renamed destination tag (ROB slot) from issue through the
// execute lanes into the ROB and clears it on commit or flush. Produces
// per-operand bypass selects and a per-tag source-ready vector.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset, clears all state
//   issue_val    per-lane issue strobe
//   issue_dst_en per-lane "writes a destination"
//   issue_dst    per-lane destination tag (TAGW bits each)
//   issue_fu     per-lane unit class: 0 ALU, 1 MEM, 2/3 MULDIV
//   stall        bit l*DEPTH+p holds lane l stage p
//   commit_val   per-commit-port valid
//   commit_slot  per-commit-port tag (TAGW bits each)
//   flush        squash every in-flight tag
//   src          operand tags, operand index l*2+k
//   src_renamed  operand refers to a tag rather than the regfile
//   byp_sel      bypass select per operand (SELW bits each)
//                0 = regfile, 1+lane*DEPTH+stage = pipe, NLANES*DEPTH+1 = ROB
//   src_ready    tag t may be consumed next cycle
//   occupancy    registered count of pending tags
module riscv_scoreboard_nw #(
  parameter int unsigned NTAGS   = 32,
  parameter int unsigned NLANES  = 2,
  parameter int unsigned DEPTH   = 5,
  parameter int unsigned NCOMMIT = 2,
  parameter int unsigned LAT_MEM = 1,
  parameter int unsigned LAT_MUL = 3,
  localparam int unsigned TAGW   = $clog2(NTAGS),
  localparam int unsigned SELW   = $clog2(NLANES*DEPTH+2),
  localparam int unsigned OCCW   = $clog2(NTAGS+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NLANES-1:0]        issue_val,
  input  logic [NLANES-1:0]        issue_dst_en,
  input  logic [NLANES*TAGW-1:0]   issue_dst,
  input  logic [NLANES*2-1:0]      issue_fu,
  input  logic [NLANES*DEPTH-1:0]  stall,
  input  logic [NCOMMIT-1:0]       commit_val,
  input  logic [NCOMMIT*TAGW-1:0]  commit_slot,
  input  logic                     flush,
  input  logic [NLANES*2*TAGW-1:0] src,
  input  logic [NLANES*2-1:0]      src_renamed,
  output logic [NLANES*2*SELW-1:0] byp_sel,
  output logic [NTAGS-1:0]         src_ready,
  output logic [OCCW-1:0]          occupancy
);

  localparam int unsigned LANEW = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int unsigned IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NTAGS-1:0]             pending_q, pending_d;
  logic [NTAGS-1:0][DEPTH-1:0]  stage_q, stage_d;
  logic [NTAGS-1:0][LANEW-1:0]  lane_q, lane_d;
  logic [NTAGS-1:0][1:0]        fu_q, fu_d;
  logic [OCCW-1:0]              occ_q, occ_d;

  logic [NTAGS-1:0]             in_pipe;
  logic [NTAGS-1:0][IDXW-1:0]   stg_idx;

  // Next-state order: advance, then commit, then issue, then flush, so that
  // each later rule overrides the earlier ones for the tag it touches.
  always_comb begin : next_state
    logic [DEPTH-1:0] hold;
    logic [TAGW-1:0]  tag;
    pending_d = pending_q;
    stage_d   = stage_q;
    lane_d    = lane_q;
    fu_d      = fu_q;
    occ_d     = '0;
    hold      = '0;
    tag       = '0;

    // One-hot stage shifts up one bit unless its lane/stage stall is set;
    // the top bit shifts out, leaving all-zero (sitting in the ROB).
    for (int unsigned t = 0; t < NTAGS; t++) begin
      hold       = DEPTH'(stall >> (32'(lane_q[t]) * DEPTH));
      stage_d[t] = (stage_q[t] & hold) | ((stage_q[t] & ~hold) << 1);
    end

    for (int unsigned c = 0; c < NCOMMIT; c++) begin
      if (commit_val[c]) begin
        tag            = commit_slot[c*TAGW +: TAGW];
        pending_d[tag] = 1'b0;
        stage_d[tag]   = '0;
      end
    end

    // Walk lanes from highest to lowest so lane 0 is applied last and wins
    // when several lanes name the same tag.
    for (int unsigned i = NLANES; i > 0; i--) begin
      if (issue_val[i-1] && issue_dst_en[i-1]) begin
        tag            = issue_dst[(i-1)*TAGW +: TAGW];
        pending_d[tag] = 1'b1;
        lane_d[tag]    = LANEW'(i-1);
        stage_d[tag]   = DEPTH'(1);
        fu_d[tag]      = issue_fu[(i-1)*2 +: 2];
      end
    end

    if (flush) begin
      pending_d = '0;
      stage_d   = '0;
    end

    for (int unsigned t = 0; t < NTAGS; t++) begin
      occ_d = occ_d + OCCW'(pending_d[t]);
    end
  end

  always_comb begin : tag_status
    stg_idx   = '0;
    in_pipe   = '0;
    src_ready = '0;
    for (int unsigned t = 0; t < NTAGS; t++) begin
      for (int unsigned p = 0; p < DEPTH; p++) begin
        if (stage_q[t][p]) stg_idx[t] = IDXW'(p);
      end
      in_pipe[t] = |stage_q[t];
      if (!pending_q[t] || !in_pipe[t]) begin
        src_ready[t] = 1'b1;
      end else if (fu_q[t] == 2'd0) begin
        src_ready[t] = 1'b1;
      end else if (fu_q[t] == 2'd1) begin
        src_ready[t] = (32'(stg_idx[t]) >= LAT_MEM);
      end else begin
        src_ready[t] = (32'(stg_idx[t]) >= LAT_MUL);
      end
    end
  end

  always_comb begin : bypass
    logic [TAGW-1:0] s;
    s       = '0;
    byp_sel = '0;
    for (int unsigned o = 0; o < NLANES*2; o++) begin
      s = src[o*TAGW +: TAGW];
      if (src_renamed[o] && pending_q[s]) begin
        if (in_pipe[s]) begin
          byp_sel[o*SELW +: SELW] =
            SELW'(1 + 32'(lane_q[s]) * DEPTH + 32'(stg_idx[s]));
        end else begin
          byp_sel[o*SELW +: SELW] = SELW'(NLANES*DEPTH + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      stage_q   <= '0;
      lane_q    <= '0;
      fu_q      <= '0;
      occ_q     <= '0;
    end else begin
      pending_q <= pending_d;
      stage_q   <= stage_d;
      lane_q    <= lane_d;
      fu_q      <= fu_d;
      occ_q     <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_riscv_scoreboard_nw.sv
// Self-checking bench for riscv_scoreboard_nw: a directed vector table,
// hand-written multi-cycle sequences, and randomized traffic compared
// against a per-tag behavioural model (integer stage, -1 = in ROB).
module tb_riscv_scoreboard_nw;

  localparam int NT  = 32;
  localparam int NL  = 2;
  localparam int D   = 5;
  localparam int NC  = 2;
  localparam int LM  = 1;
  localparam int LX  = 3;
  localparam int TW  = 5;
  localparam int SW  = 4;
  localparam int OW  = 6;
  localparam int ROB = NL*D + 1;

  logic              clk;
  logic              reset;
  logic [NL-1:0]     issue_val;
  logic [NL-1:0]     issue_dst_en;
  logic [NL*TW-1:0]  issue_dst;
  logic [NL*2-1:0]   issue_fu;
  logic [NL*D-1:0]   stall;
  logic [NC-1:0]     commit_val;
  logic [NC*TW-1:0]  commit_slot;
  logic              flush;
  logic [NL*2*TW-1:0] src;
  logic [NL*2-1:0]   src_renamed;
  logic [NL*2*SW-1:0] byp_sel;
  logic [NT-1:0]     src_ready;
  logic [OW-1:0]     occupancy;

  riscv_scoreboard_nw #(
    .NTAGS(NT), .NLANES(NL), .DEPTH(D), .NCOMMIT(NC), .LAT_MEM(LM), .LAT_MUL(LX)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_val(issue_val), .issue_dst_en(issue_dst_en), .issue_dst(issue_dst),
    .issue_fu(issue_fu), .stall(stall),
    .commit_val(commit_val), .commit_slot(commit_slot), .flush(flush),
    .src(src), .src_renamed(src_renamed),
    .byp_sel(byp_sel), .src_ready(src_ready), .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_pend [NT];
  int m_lane [NT];
  int m_stage[NT];   // 0..D-1 in a pipe stage, -1 = sitting in the ROB
  int m_fu   [NT];

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      m_pend[t] = 0; m_lane[t] = 0; m_stage[t] = -1; m_fu[t] = 0;
    end
  endtask

  task automatic model_step();
    bit claimed[NT];
    int s;
    for (int t = 0; t < NT; t++) begin
      claimed[t] = 0;
      if (m_pend[t] && m_stage[t] >= 0) begin
        if (!stall[m_lane[t]*D + m_stage[t]]) begin
          m_stage[t] = m_stage[t] + 1;
          if (m_stage[t] == D) m_stage[t] = -1;
        end
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (commit_val[c]) begin
        s = int'(commit_slot[c*TW +: TW]);
        m_pend[s] = 0; m_stage[s] = -1;
      end
    end
    for (int l = 0; l < NL; l++) begin
      if (issue_val[l] && issue_dst_en[l]) begin
        s = int'(issue_dst[l*TW +: TW]);
        if (!claimed[s]) begin
          claimed[s] = 1;
          m_pend[s] = 1; m_lane[s] = l; m_stage[s] = 0;
          m_fu[s] = int'(issue_fu[l*2 +: 2]);
        end
      end
    end
    if (flush) begin
      for (int t = 0; t < NT; t++) begin
        m_pend[t] = 0; m_stage[t] = -1;
      end
    end
  endtask

  function automatic int m_byp(input int s, input bit ren);
    if (!ren || !m_pend[s]) return 0;
    if (m_stage[s] >= 0) return 1 + m_lane[s]*D + m_stage[s];
    return ROB;
  endfunction

  function automatic bit m_rdy(input int t);
    if (!m_pend[t] || m_stage[t] < 0) return 1;
    if (m_fu[t] == 0) return 1;
    if (m_fu[t] == 1) return m_stage[t] >= LM;
    return m_stage[t] >= LX;
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int t = 0; t < NT; t++) n += int'(m_pend[t]);
    return n;
  endfunction

  task automatic check_model(input string tag);
    logic [NT-1:0] er;
    for (int o = 0; o < NL*2; o++) begin
      chk($sformatf("%s byp op%0d", tag, o), 64'(byp_sel[o*SW +: SW]),
          64'(m_byp(int'(src[o*TW +: TW]), src_renamed[o])));
    end
    for (int t = 0; t < NT; t++) er[t] = m_rdy(t);
    chk($sformatf("%s src_ready", tag), 64'(src_ready), 64'(er));
    chk($sformatf("%s occupancy", tag), 64'(occupancy), 64'(m_occ()));
  endtask

  // ---------------- drive helpers ----------------
  task automatic idle();
    issue_val = '0; issue_dst_en = '0; issue_dst = '0; issue_fu = '0;
    stall = '0; commit_val = '0; commit_slot = '0; flush = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    #1;
  endtask

  task automatic issue(input int l, input int tag, input int fu);
    issue_val[l] = 1'b1;
    issue_dst_en[l] = 1'b1;
    issue_dst[l*TW +: TW] = TW'(tag);
    issue_fu[l*2 +: 2] = 2'(fu);
  endtask

  typedef struct {
    logic [1:0] iv; int d0; int d1; int f0; int f1;
    logic [1:0] cv; int c0; int c1;
    logic [9:0] st; logic fl;
    int s; logic ren;
    int e_byp; logic e_rdy; int e_occ;
  } vec_t;

  vec_t tv[17];

  function automatic int pick_pending(input int start);
    for (int i = 0; i < NT; i++) begin
      if (m_pend[(start + i) % NT]) return (start + i) % NT;
    end
    return start;
  endfunction

  initial begin
    // iv   d0 d1 f0 f1  cv    c0 c1  st     fl    s  ren   byp rdy   occ
    tv[0]  = '{2'b01, 7, 0, 0, 0, 2'b00, 0, 0, 10'd0, 1'b0, 7, 1'b1, 1,   1'b1, 1};
    tv[1]  = '{2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10'd0, 1'b0, 7, 1'b1, 2,   1'b1, 1};
    tv[2]  = '{2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10'd0, 1'b0, 7, 1'b1, 3,   1'b1, 1};
    tv[3]  = '{2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10'd0, 1'b0, 7, 1'b1, 4,   1'b1, 1};
    tv[4]  = '{2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10'd0, 1'b0, 7, 1'b1, 5,   1'b1, 1};
    tv[5]  = '{2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10'd0, 1'b0, 7, 1'b1, ROB, 1'b1, 1};
    tv[6]  = '{2'b00, 0, 0, 0, 0, 2'b01, 7, 0, 10'd0, 1'b0, 7, 1'b1, 0,   1'b1, 0};
    tv[7]  = '{2'b01, 9, 0, 2, 0, 2'b00, 0, 0, 10'd0, 1'b0, 9, 1'b1, 1,   1'b0, 1};
    tv[8]  = '{2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10'd0, 1'b0, 9, 1'b1, 2,   1'b0, 1};
    tv[9]  = '{2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10'd0, 1'b0, 9, 1'b1, 3,   1'b0, 1};
    tv[10] = '{2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10'd0, 1'b0, 9, 1'b1, 4,   1'b1, 1};
    tv[11] = '{2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10'd0, 1'b0, 9, 1'b0, 0,   1'b1, 1};
    tv[12] = '{2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10'd0, 1'b0, 9, 1'b1, ROB, 1'b1, 1};
    tv[13] = '{2'b11, 4, 4, 0, 1, 2'b00, 0, 0, 10'd0, 1'b0, 4, 1'b1, 1,   1'b1, 2};
    tv[14] = '{2'b10, 0,12, 0, 0, 2'b11,12, 9, 10'd0, 1'b0,12, 1'b1, 6,   1'b1, 2};
    tv[15] = '{2'b00, 0, 0, 0, 0, 2'b11,20,20, 10'd0, 1'b0, 4, 1'b1, 3,   1'b1, 2};
    tv[16] = '{2'b00, 0, 0, 0, 0, 2'b11, 4,12, 10'd0, 1'b0,12, 1'b1, 0,   1'b1, 0};

    // ---- reset state ----
    reset = 1'b0;
    idle();
    src = '0; src_renamed = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    src[4:0] = 5'd7; src_renamed = '1;
    #1;
    chk("reset byp_sel", 64'(byp_sel), 64'(0));
    chk("reset src_ready", 64'(src_ready), 64'(32'hFFFF_FFFF));
    chk("reset occupancy", 64'(occupancy), 64'(0));
    reset = 1'b1;
    src_renamed = '0;

    // ---- directed vector table ----
    for (int i = 0; i < 17; i++) begin
      issue_val = tv[i].iv; issue_dst_en = tv[i].iv;
      issue_dst = {TW'(tv[i].d1), TW'(tv[i].d0)};
      issue_fu = {2'(tv[i].f1), 2'(tv[i].f0)};
      commit_val = tv[i].cv;
      commit_slot = {TW'(tv[i].c1), TW'(tv[i].c0)};
      stall = tv[i].st; flush = tv[i].fl;
      src = '0; src[4:0] = TW'(tv[i].s);
      src_renamed = '0; src_renamed[0] = tv[i].ren;
      cycle();
      chk($sformatf("row%0d byp", i), 64'(byp_sel[SW-1:0]), 64'(tv[i].e_byp));
      chk($sformatf("row%0d rdy", i), 64'(src_ready[tv[i].s]), 64'(tv[i].e_rdy));
      chk($sformatf("row%0d occ", i), 64'(occupancy), 64'(tv[i].e_occ));
    end

    // ---- MEM result held at X0 by a lane-1 stall ----
    idle();
    src = '0; src[4:0] = 5'd3; src_renamed = 4'b0001;
    issue(1, 3, 1);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("memstall hold%0d byp", i), 64'(byp_sel[SW-1:0]), 64'(6));
      chk($sformatf("memstall hold%0d rdy", i), 64'(src_ready[3]), 64'(0));
      check_model("memstall");
      stall[1*D+0] = (i < 2);
      cycle();
    end
    chk("memstall release byp", 64'(byp_sel[SW-1:0]), 64'(7));
    chk("memstall release rdy", 64'(src_ready[3]), 64'(1));
    idle();
    commit_val = 2'b01; commit_slot = '0; commit_slot[4:0] = 5'd3;
    cycle();
    chk("memstall commit byp", 64'(byp_sel[SW-1:0]), 64'(0));
    idle();

    // ---- 10 tags in flight, flush with a same-cycle issue ----
    for (int i = 0; i < 5; i++) begin
      idle();
      issue(0, 10 + 2*i, i % 4);
      issue(1, 11 + 2*i, (i + 1) % 4);
      cycle();
    end
    idle();
    chk("flush pre occupancy", 64'(occupancy), 64'(10));
    flush = 1'b1;
    issue(0, 25, 2);
    src = {5'd25, 5'd19, 5'd15, 5'd10}; src_renamed = '1;
    cycle();
    idle();
    chk("flush byp_sel", 64'(byp_sel), 64'(0));
    chk("flush src_ready", 64'(src_ready), 64'(32'hFFFF_FFFF));
    chk("flush occupancy", 64'(occupancy), 64'(0));

    // ---- reset asserted mid-stream ----
    for (int i = 0; i < 3; i++) begin
      idle();
      issue(0, 2*i, 2);
      issue(1, 2*i + 1, 1);
      cycle();
    end
    idle();
    src = {5'd5, 5'd4, 5'd1, 5'd0}; src_renamed = '1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midreset byp_sel", 64'(byp_sel), 64'(0));
    chk("midreset src_ready", 64'(src_ready), 64'(32'hFFFF_FFFF));
    chk("midreset occupancy", 64'(occupancy), 64'(0));
    cycle();
    #1;
    reset = 1'b1;
    cycle();
    check_model("postreset");

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int l = 0; l < NL; l++) begin
        issue_val[l] = ($urandom_range(0, 1) == 1);
        issue_dst_en[l] = ($urandom_range(0, 7) != 0);
        issue_dst[l*TW +: TW] = TW'($urandom_range(0, NT-1));
        issue_fu[l*2 +: 2] = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) issue_dst[2*TW-1:TW] = issue_dst[TW-1:0];
      for (int b = 0; b < NL*D; b++) stall[b] = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < NC; c++) begin
        commit_val[c] = ($urandom_range(0, 2) != 0);
        commit_slot[c*TW +: TW] = ($urandom_range(0, 1) == 1)
          ? TW'(pick_pending(int'($urandom_range(0, NT-1))))
          : TW'($urandom_range(0, NT-1));
      end
      flush = ($urandom_range(0, 39) == 0);
      cycle();
      for (int o = 0; o < NL*2; o++) begin
        src[o*TW +: TW] = ($urandom_range(0, 3) != 0)
          ? TW'(pick_pending(int'($urandom_range(0, NT-1))))
          : TW'($urandom_range(0, NT-1));
        src_renamed[o] = ($urandom_range(0, 4) != 0);
      end
      #1;
      check_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
